// File: rtl/multi_channel_phase_cordic.sv
// N-channel phase extractor: snapshots every channel's complex sample and runs one
// shared iterative vectoring CORDIC over the unmasked channels, publishing all phases at once.
module multi_channel_phase_cordic #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned IN_W = 28,
  parameter int unsigned PH_W = 16,
  parameter int unsigned ITER = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic [N_CH*IN_W-1:0]   re_in,
  input  logic [N_CH*IN_W-1:0]   im_in,
  output logic [N_CH*PH_W-1:0]   phase_out,
  output logic                   valid,
  output logic                   busy,
  output logic                   overrun
);
  // Fraction bits below the input LSB keep shift truncation small for low-amplitude inputs;
  // z carries extra fraction bits so the rounded atan table adds no visible error.
  localparam int unsigned FRAC_W = 12;
  localparam int unsigned XW     = IN_W + 2 + FRAC_W;
  localparam int unsigned ZG     = 4;
  localparam int unsigned ZW     = PH_W + ZG;
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned IT_W   = $clog2(ITER);

  // atan(2^-i) scaled so that pi = 2^31
  localparam logic [31:0] ATAN_Q31 [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10680350,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_STORE, S_DONE} state_t;

  state_t                  state, state_n;
  logic [CH_W-1:0]         ch;
  logic [IT_W-1:0]         iter_cnt;
  logic [N_CH-1:0]         mask_s;
  logic [N_CH*IN_W-1:0]    re_s, im_s;
  logic [N_CH*PH_W-1:0]    stage;
  logic signed [XW-1:0]    x, y;
  logic [ZW-1:0]           z;

  logic                    capture;
  logic [CH_W:0]           first_c, next_c;
  logic [IN_W-1:0]         re_cur, im_cur;
  logic signed [XW-1:0]    re_x, im_x, x_sh, y_sh;
  logic [ZW-1:0]           atan_c;
  logic [PH_W-1:0]         ph_c;

  // Lowest set mask bit at or above start, as {found, index}
  function automatic logic [CH_W:0] first_set(input logic [N_CH-1:0] m, input int start);
    logic [CH_W:0] r;
    r = '0;
    for (int k = int'(N_CH) - 1; k >= 0; k--)
      if (m[k] && k >= start) r = {1'b1, CH_W'(k)};
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    first_c = first_set(ch_mask, 0);
    next_c  = first_set(mask_s, int'(ch) + 1);
    case (state)
      S_IDLE: begin
        if (enable) begin
          capture = 1'b1;
          state_n = first_c[CH_W] ? S_LOAD : S_DONE;
        end
      end
      S_LOAD:  state_n = S_ITER;
      S_ITER:  if (iter_cnt == IT_W'(ITER - 1)) state_n = S_STORE;
      S_STORE: state_n = next_c[CH_W] ? S_LOAD : S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Current-channel operands and one micro-rotation's shifted terms
  always_comb begin
    re_cur = re_s[ch*IN_W +: IN_W];
    im_cur = im_s[ch*IN_W +: IN_W];
    re_x   = {{2{re_cur[IN_W-1]}}, re_cur, {FRAC_W{1'b0}}};
    im_x   = {{2{im_cur[IN_W-1]}}, im_cur, {FRAC_W{1'b0}}};
    x_sh   = x >>> iter_cnt;
    y_sh   = y >>> iter_cnt;
    atan_c = ZW'((33'(ATAN_Q31[5'(iter_cnt)]) + (33'd1 << (31 - ZW))) >> (32 - ZW));
    ph_c   = ((re_cur == '0) && (im_cur == '0)) ? '0
           : PH_W'((z + ZW'(1 << (ZG - 1))) >> ZG);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch        <= '0;
      iter_cnt  <= '0;
      mask_s    <= '0;
      re_s      <= '0;
      im_s      <= '0;
      stage     <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      phase_out <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= enable && busy;
      if (capture) begin
        re_s   <= re_in;
        im_s   <= im_in;
        mask_s <= ch_mask;
        ch     <= first_c[CH_W-1:0];
        busy   <= 1'b1;
      end
      case (state)
        S_LOAD: begin
          iter_cnt <= '0;
          if (re_cur[IN_W-1]) begin
            x <= -re_x;
            y <= -im_x;
            z <= {1'b1, {(ZW-1){1'b0}}};
          end else begin
            x <= re_x;
            y <= im_x;
            z <= '0;
          end
        end
        S_ITER: begin
          iter_cnt <= iter_cnt + IT_W'(1);
          if (!y[XW-1]) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_c;
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_c;
          end
        end
        S_STORE: begin
          stage[ch*PH_W +: PH_W] <= ph_c;
          if (next_c[CH_W]) ch <= next_c[CH_W-1:0];
        end
        S_DONE: begin
          for (int k = 0; k < int'(N_CH); k++)
            if (mask_s[k]) phase_out[k*PH_W +: PH_W] <= stage[k*PH_W +: PH_W];
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_channel_phase_cordic.sv
// Directed bench for multi_channel_phase_cordic: quadrants, extremes, masking,
// overrun/back-to-back handshake and mid-frame reset.
module tb_multi_channel_phase_cordic;
  localparam int N_CH = 4;
  localparam int IN_W = 28;
  localparam int PH_W = 16;
  localparam int LIM  = 200;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  enable = 1'b0;
  logic [N_CH-1:0]       ch_mask = '0;
  logic [N_CH*IN_W-1:0]  re_in = '0;
  logic [N_CH*IN_W-1:0]  im_in = '0;
  logic [N_CH*PH_W-1:0]  phase_out;
  logic                  valid, busy, overrun;

  int total = 0;
  int bad   = 0;

  multi_channel_phase_cordic #(.N_CH(N_CH), .IN_W(IN_W), .PH_W(PH_W), .ITER(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .re_in(re_in), .im_in(im_in), .phase_out(phase_out),
    .valid(valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_ph(input string tag, input int k, input int exp_v);
    logic signed [15:0] obs, d;
    logic ok;
    obs = phase_out[k*PH_W +: PH_W];
    d   = obs - 16'(exp_v);
    ok  = !$isunknown(obs) && (d >= -16'sd4) && (d <= 16'sd4);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s ch%0d: got %0d want %0d+-4", tag, k, obs, exp_v);
    end
  endtask

  task automatic set_ch(input int k, input int re, input int im);
    re_in[k*IN_W +: IN_W] = IN_W'(re);
    im_in[k*IN_W +: IN_W] = IN_W'(im);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Capture a frame, optionally pulse enable again at cycle ov_at, check latency and pulse width
  task automatic run_frame(input string tag, input logic [N_CH-1:0] m, input int exp_lat,
                           input int ov_at);
    int lat;
    lat = -1;
    ch_mask = m;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int cyc = 1; cyc <= LIM; cyc++) begin
      if (cyc == ov_at) begin
        enable = 1'b1;
        re_in  = {$urandom, $urandom, $urandom, $urandom};
        im_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      enable = 1'b0;
      if (ov_at > 0 && cyc == ov_at)     chk({tag, "_ovr_on"},  32'(overrun), 32'd1);
      if (ov_at > 0 && cyc == ov_at + 1) chk({tag, "_ovr_off"}, 32'(overrun), 32'd0);
      if (valid === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_pulse"}, 32'(valid), 32'd0);
  endtask

  task automatic set_quadrants();
    set_ch(0, 1000, 0);
    set_ch(1, 0, 1000);
    set_ch(2, -1000, 0);
    set_ch(3, 1000, -1000);
  endtask

  task automatic chk_quadrants(input string tag);
    chk_ph(tag, 0, 0);
    chk_ph(tag, 1, 16384);
    chk_ph(tag, 2, -32768);
    chk_ph(tag, 3, -8192);
  endtask

  initial begin
    int lat;
    int seen;

    // 1: asynchronous reset between clock edges
    #3 reset = 1'b1;
    #1;
    chk("rst_phase", 32'(phase_out == '0), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_stay", 32'({valid, busy, overrun, |phase_out}), 32'd0);

    // 2: four quadrants
    set_quadrants();
    run_frame("quad", 4'hF, 73, 0);
    chk_quadrants("quad");

    // 3: extremes
    set_ch(0, -(1 << 27), -(1 << 27));
    set_ch(1, (1 << 27) - 1, 0);
    set_ch(2, 0, 0);
    set_ch(3, -(1 << 27), 1);
    run_frame("ext", 4'hF, 73, 0);
    chk_ph("ext", 0, -24576);
    chk_ph("ext", 1, 0);
    chk("ext_zero", 32'(phase_out[2*PH_W +: PH_W]), 32'd0);
    chk_ph("ext", 3, -32768);

    // 4: mask
    set_ch(0, 1000, 0);
    set_ch(1, 0, 1000);
    set_ch(2, 0, -1000);
    set_ch(3, -1000, 1000);
    run_frame("mask1", 4'hF, 73, 0);
    chk_ph("mask1", 0, 0);
    chk_ph("mask1", 1, 16384);
    chk_ph("mask1", 2, -16384);
    chk_ph("mask1", 3, 24576);
    set_ch(0, 0, -500);
    set_ch(1, 1000, 0);
    set_ch(2, 1000, 1000);
    set_ch(3, 1000, 0);
    run_frame("mask2", 4'b0101, 37, 0);
    chk_ph("mask2", 0, -16384);
    chk_ph("mask2", 1, 16384);
    chk_ph("mask2", 2, 8192);
    chk_ph("mask2", 3, 24576);
    set_ch(0, 1000, 0);
    run_frame("mask0", 4'b0000, 1, 0);
    chk_ph("mask0", 0, -16384);
    chk_ph("mask0", 2, 8192);

    // 5a: enable during a frame
    set_quadrants();
    run_frame("ovr", 4'hF, 73, 10);
    chk_quadrants("ovr");

    // 5b: enable held high, frames run back to back
    set_quadrants();
    set_ch(0, 0, -1000);
    ch_mask = 4'hF;
    enable  = 1'b1;
    tick();
    lat = -1;
    for (int cyc = 1; cyc <= LIM; cyc++) begin
      tick();
      if (valid === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    chk("b2b_lat1", 32'(lat), 32'd73);
    chk_ph("b2b1", 0, -16384);
    set_ch(0, 1000, 0);
    tick();
    chk("b2b_recapture", 32'(busy), 32'd1);
    lat = -1;
    for (int cyc = 1; cyc <= LIM; cyc++) begin
      tick();
      if (valid === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    enable = 1'b0;
    chk("b2b_lat2", 32'(lat), 32'd73);
    chk_quadrants("b2b2");
    tick();

    // 6: reset in the middle of a frame
    set_ch(0, 0, 1000);
    ch_mask = 4'hF;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
    for (int i = 0; i < 29; i++) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_phase", 32'(phase_out == '0), 32'd1);
    chk("midrst_flags", 32'({valid, busy, overrun}), 32'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (valid !== 1'b0) seen++;
    end
    chk("midrst_novalid", 32'(seen), 32'd0);
    set_quadrants();
    run_frame("after_rst", 4'hF, 73, 0);
    chk_quadrants("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
